// File: rtl/d_p_ram_pipe_if.sv
// Bus bundle for d_p_ram_pipe: one write port, one read port, ready/valid status.
// Handshake: a write or read request is taken on a rising edge only while ready=1;
// read_valid is a one-cycle strobe marking output_data as fresh, and there is no
// read backpressure.
interface d_p_ram_pipe_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
);
    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

    logic                  write_en;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [NUM_BYTES-1:0]  write_be;
    logic [DATA_WIDTH-1:0] input_data;
    logic                  read_en;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [DATA_WIDTH-1:0] output_data;
    logic                  read_valid;
    logic                  ready;

    modport master (
        output write_en, write_addr, write_be, input_data, read_en, read_addr,
        input  output_data, read_valid, ready
    );

    modport slave (
        input  write_en, write_addr, write_be, input_data, read_en, read_addr,
        output output_data, read_valid, ready
    );
endinterface

// File: rtl/d_p_ram_pipe.sv
// Simple dual-port RAM, single clock: byte-enabled write port, pipelined read port
// with read-valid strobe, selectable read-during-write policy and an optional
// post-reset clear engine. The array itself has no reset so it maps onto block RAM.
module d_p_ram_pipe #(
    parameter int ADDR_WIDTH     = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int DEPTH          = 1 << ADDR_WIDTH,
    parameter int READ_LATENCY   = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    d_p_ram_pipe_if.slave bus,
    output logic [1:0] o_dbg_state
);
    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_INIT  = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;
    localparam logic [1:0] ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_INIT;

    localparam logic [ADDR_WIDTH:0]   LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LP_LAST  = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_ram_q;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_clear_addr;

    // Read stage 0: captured alongside the RAM read, used to fix up the raw word.
    logic                  r_acc_v;
    logic                  r_acc_oor;
    logic                  r_byp_hit;
    logic [NUM_BYTES-1:0]  r_byp_be;
    logic [DATA_WIDTH-1:0] r_byp_data;

    // Output pipeline; the last stage drives output_data/read_valid.
    logic                  r_pv [1:READ_LATENCY];
    logic [DATA_WIDTH-1:0] r_pd [1:READ_LATENCY];

    logic                  w_ready;
    logic                  w_clearing;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_rd_in;
    logic [ADDR_WIDTH-1:0] w_rd_idx;
    logic [NUM_BYTES-1:0]  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_data;
    logic [DATA_WIDTH-1:0] w_word;

    assign w_ready    = (r_state == ST_RUN);
    assign w_clearing = (r_state == ST_CLEAR);
    assign w_wr_acc   = w_ready && bus.write_en && ({1'b0, bus.write_addr} < LP_DEPTH);
    assign w_rd_acc   = w_ready && bus.read_en;
    assign w_rd_in    = ({1'b0, bus.read_addr} < LP_DEPTH);
    assign w_rd_idx   = w_rd_in ? bus.read_addr : '0;

    // Write-port mux: clear engine owns the port while clearing, else user writes.
    always_comb begin
        w_mem_we   = '0;
        w_mem_addr = bus.write_addr;
        w_mem_data = bus.input_data;
        if (w_clearing) begin
            w_mem_we   = '1;
            w_mem_addr = r_clear_addr;
            w_mem_data = '0;
        end else if (w_wr_acc) begin
            w_mem_we   = bus.write_be;
        end
    end

    // Clear/init sequencer: walks every word once after reset, then runs forever.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RESET;
            r_clear_addr <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_clear_addr == LP_LAST) r_state <= ST_RUN;
                    else                         r_clear_addr <= r_clear_addr + 1'b1;
                end
                ST_INIT: r_state <= ST_RUN;
                ST_RUN:  r_state <= ST_RUN;
                default: r_state <= ST_RESET;
            endcase
        end
    end

    // Block RAM body: byte-lane writes and a registered read (old data on collision).
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (w_mem_we[i]) r_mem[w_mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= w_mem_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        if (w_rd_acc) r_ram_q <= r_mem[w_rd_idx];
    end

    // Stage-0 side information: range check and same-address write for bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_v    <= 1'b0;
            r_acc_oor  <= 1'b0;
            r_byp_hit  <= 1'b0;
            r_byp_be   <= '0;
            r_byp_data <= '0;
        end else begin
            r_acc_v <= w_rd_acc;
            if (w_rd_acc) begin
                r_acc_oor  <= !w_rd_in;
                r_byp_hit  <= w_wr_acc && (bus.write_addr == bus.read_addr);
                r_byp_be   <= bus.write_be;
                r_byp_data <= bus.input_data;
            end
        end
    end

    // Final read word: zero when out of range, merged with the colliding write in bypass mode.
    always_comb begin
        w_word = r_ram_q;
        if (r_acc_oor) begin
            w_word = '0;
        end else if ((RDW_MODE != 0) && r_byp_hit) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (r_byp_be[i]) w_word[i*BYTE_WIDTH +: BYTE_WIDTH] = r_byp_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Output pipeline: data moves only with its valid bit, so the output holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= READ_LATENCY; i++) begin
                r_pv[i] <= 1'b0;
                r_pd[i] <= '0;
            end
        end else begin
            r_pv[1] <= r_acc_v;
            if (r_acc_v) r_pd[1] <= w_word;
            for (int i = 2; i <= READ_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                if (r_pv[i-1]) r_pd[i] <= r_pd[i-1];
            end
        end
    end

    assign bus.output_data = r_pd[READ_LATENCY];
    assign bus.read_valid  = r_pv[READ_LATENCY];
    assign bus.ready       = w_ready;
    assign o_dbg_state     = r_state;
endmodule
